// File: rtl/toggle_scan.sv
// -----------------------------------------------------------------------------
// toggle_scan
// Multi-channel push-on/push-off controller. A single debounce and edge engine
// is time-shared round-robin across all channels. Each channel gets one
// evaluation (EVAL) cycle per frame. A debounced rising edge on a channel flips
// that channel's latched output. A host write port can force any channel's
// output to a given value; the write takes effect at that channel's next EVAL.
//
// Parameters:
//   CHANNELS  number of channels (1..64)
//   DEBOUNCE  consecutive differing samples needed to accept a new level (>=1)
//   SCAN_DIV  clocks per channel slot (>=2)
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-high
//   din        raw asynchronous channel inputs
//   set_valid  host write request
//   set_ready  write port can accept a request (low while a write is pending)
//   set_chan   channel index of the write (out-of-range index is dropped)
//   set_value  value forced onto dout[set_chan]
//   dout       latched toggle outputs
//   o_event    (only with TOGGLE_SCAN_EVENT_EN) one-clock pulse per
//              toggle-induced change of dout; named o_event because "event"
//              is a reserved word
//
// Optional feature macro: TOGGLE_SCAN_EVENT_EN
// -----------------------------------------------------------------------------
module toggle_scan #(
   parameter int unsigned CHANNELS = 8,
   parameter int unsigned DEBOUNCE = 16,
   parameter int unsigned SCAN_DIV = 4,
   localparam int unsigned PTR_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] din,
   input  logic                set_valid,
   output logic                set_ready,
   input  logic [PTR_W-1:0]    set_chan,
   input  logic                set_value,
   output logic [CHANNELS-1:0] dout
`ifdef TOGGLE_SCAN_EVENT_EN
   ,
   output logic [CHANNELS-1:0] o_event
`endif
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
   localparam int unsigned DIV_W = $clog2(SCAN_DIV);

   logic [CHANNELS-1:0] r_sync1;
   logic [CHANNELS-1:0] r_sync2;
   logic [CHANNELS-1:0] r_stable;
   logic [CHANNELS-1:0] r_dout;
   logic [CNT_W-1:0]    r_cnt [CHANNELS];
   logic [DIV_W-1:0]    r_div;
   logic [PTR_W-1:0]    r_ptr;
   logic                r_pend;
   logic [PTR_W-1:0]    r_pend_chan;
   logic                r_pend_val;
   logic                r_ready;
`ifdef TOGGLE_SCAN_EVENT_EN
   logic [CHANNELS-1:0] r_event;
`endif

   logic             w_eval;
   logic             w_s;
   logic             w_l;
   logic [CNT_W-1:0] w_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_qual;
   logic             w_pend_bad;
   logic             w_pend_hit;
   logic [PTR_W-1:0] w_ptr_next;

   // Shared engine: view of the channel currently owning the slot
   always_comb begin
      w_eval     = (r_div == DIV_W'(SCAN_DIV - 1));
      w_s        = r_sync2[r_ptr];
      w_l        = r_stable[r_ptr];
      w_cnt      = r_cnt[r_ptr];
      w_cnt_inc  = w_cnt + CNT_W'(1);
      w_qual     = (w_s != w_l) && (w_cnt_inc == CNT_W'(DEBOUNCE));
      w_pend_bad = ({1'b0, r_pend_chan} >= (PTR_W + 1)'(CHANNELS));
      w_pend_hit = r_pend && !w_pend_bad && (r_pend_chan == r_ptr);
      w_ptr_next = (r_ptr == PTR_W'(CHANNELS - 1)) ? '0 : r_ptr + PTR_W'(1);
   end

   // Synchronizers, scheduler, debounce, toggle and write handling
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_stable    <= '0;
         r_dout      <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
         r_div       <= '0;
         r_ptr       <= '0;
         r_pend      <= 1'b0;
         r_pend_chan <= '0;
         r_pend_val  <= 1'b0;
         r_ready     <= 1'b1;
`ifdef TOGGLE_SCAN_EVENT_EN
         r_event     <= '0;
`endif
      end else begin
         r_sync1 <= din;
         r_sync2 <= r_sync1;
`ifdef TOGGLE_SCAN_EVENT_EN
         r_event <= '0;
`endif
         if (w_eval) begin
            r_div <= '0;
            r_ptr <= w_ptr_next;
            if (w_s == w_l) begin
               r_cnt[r_ptr] <= '0;
            end else if (w_qual) begin
               r_stable[r_ptr] <= w_s;
               r_cnt[r_ptr]    <= '0;
               // A pending write to this channel overrides the toggle
               if (w_s && !w_pend_hit) begin
                  r_dout[r_ptr] <= ~r_dout[r_ptr];
`ifdef TOGGLE_SCAN_EVENT_EN
                  r_event[r_ptr] <= 1'b1;
`endif
               end
            end else begin
               r_cnt[r_ptr] <= w_cnt_inc;
            end
            if (w_pend_hit) r_dout[r_ptr] <= r_pend_val;
            // Out-of-range writes are dropped at the first EVAL of any channel
            if (r_pend && (w_pend_bad || w_pend_hit)) begin
               r_pend  <= 1'b0;
               r_ready <= 1'b1;
            end
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
         if (set_valid && r_ready) begin
            r_pend      <= 1'b1;
            r_pend_chan <= set_chan;
            r_pend_val  <= set_value;
            r_ready     <= 1'b0;
         end
      end
   end

   assign dout      = r_dout;
   assign set_ready = r_ready;
`ifdef TOGGLE_SCAN_EVENT_EN
   assign o_event   = r_event;
`endif

endmodule
